// File: rtl/filter_tdm_pkg.sv
// ---------------------------------------------------------------------------
// filter_tdm_pkg
// Shared types and default constants for the time-shared filter sequencer.
//   state_t           : sequencer state (IDLE / RUN / DRAIN)
//   DEF_CLKS_PER_SAM  : default system clocks per sample-enable
//   DEF_SAMS_PER_SYM  : default sample-enables per symbol-enable
//   DEF_P             : default symbol period in clocks
// ---------------------------------------------------------------------------
package filter_tdm_pkg;

    localparam int DEF_CLKS_PER_SAM = 4;
    localparam int DEF_SAMS_PER_SYM = 4;
    localparam int DEF_P            = DEF_CLKS_PER_SAM * DEF_SAMS_PER_SYM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up counter with enable and synchronous clear.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_en          : advance the count this clock
//   i_clr         : force the count to 0 on this clock (wins over i_en)
//   o_count       : current count (registered)
//   o_count_next  : value the count takes at the next edge
//   o_wrap        : count is MOD-1 and advancing to 0 this clock
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int MOD = 16,
    parameter int W   = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = i_en && !i_clr && (r_count == LAST);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else leaves it unassigned (which would infer a latch).
    always_comb begin
        o_count_next = r_count;
        if (i_clr)
            o_count_next = '0;
        else if (i_en)
            o_count_next = (r_count == LAST) ? '0 : r_count + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else
            r_count <= o_count_next;
    end

endmodule

// File: rtl/filter_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// filter_tdm_sequencer
// Control sequencer for a time-shared (TDM) FIR filter. One symbol period is
// P = CLKS_PER_SAM*SAMS_PER_SYM clocks; phase walks 0..P-1 while the shared
// multiplier/accumulator steps through the taps.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   run         : level request for continuous sequencing
//   sw          : coefficient bank request (sampled at symbol start)
//   sam_clk_en  : one-clock sample strobe
//   sym_clk_en  : one-clock symbol strobe (phase 0 of each symbol)
//   phase       : symbol-period clock count
//   acc_clear   : accumulators load rather than add (phase MAC_LAT)
//   acc_dump    : previous symbol's accumulator totals are final
//   bank_sel    : coefficient bank for the current symbol
//   sym_count   : symbols started since reset, modulo 256
//   busy        : sequencer not idle
// All outputs are registered: each is computed from the next-state values and
// loaded on the same edge as the state, so it lines up with the phase it marks.
// ---------------------------------------------------------------------------
module filter_tdm_sequencer
    import filter_tdm_pkg::*;
#(
    parameter int CLKS_PER_SAM = DEF_CLKS_PER_SAM,
    parameter int SAMS_PER_SYM = DEF_SAMS_PER_SYM,
    parameter int MAC_LAT      = 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] sw,
    output logic       sam_clk_en,
    output logic       sym_clk_en,
    output logic [3:0] phase,
    output logic       acc_clear,
    output logic       acc_dump,
    output logic [1:0] bank_sel,
    output logic [7:0] sym_count,
    output logic       busy
);

    localparam int P  = CLKS_PER_SAM * SAMS_PER_SYM;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] MAC_PH = CW'(MAC_LAT % P);

    state_t        r_state,  w_state_nxt;
    logic          r_active, w_active_nxt;  // a symbol is in progress
    logic          r_done,   w_done_nxt;    // a full symbol finished since leaving IDLE
    logic [CW-1:0] w_cnt, w_cnt_nxt;
    logic          w_wrap, w_cnt_en, w_cnt_clr, w_tail_end;
    logic          w_sam_nxt, w_sym_nxt, w_clear_nxt, w_dump_nxt;

    // After the last symbol of a drain, the counter keeps running into the
    // next period with no symbol active, just long enough to reach phase
    // MAC_LAT where the final accumulator totals are dumped.
    assign w_tail_end = (r_state == ST_DRAIN) && !r_active && (w_cnt == MAC_PH);
    assign w_cnt_en   = (r_state != ST_IDLE);
    assign w_cnt_clr  = (r_state == ST_IDLE) || w_tail_end;

    mod_counter #(
        .MOD (P),
        .W   (CW)
    ) u_phase_cnt (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_cnt_en),
        .i_clr        (w_cnt_clr),
        .o_count      (w_cnt),
        .o_count_next (w_cnt_nxt),
        .o_wrap       (w_wrap)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_done_nxt   = r_done;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt  = ST_RUN;
                    w_active_nxt = 1'b1;
                    w_done_nxt   = 1'b0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (r_active) begin
                    // run is only honoured at symbol boundaries, so a started
                    // symbol always completes all P phases.
                    if (w_wrap) begin
                        w_done_nxt = 1'b1;
                        if (run) begin
                            w_state_nxt  = ST_RUN;
                            w_active_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = ST_DRAIN;
                            w_active_nxt = 1'b0;
                        end
                    end else if (!run) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (w_tail_end) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_active_nxt = 1'b0;
                w_done_nxt   = 1'b0;
            end
        endcase
    end

    assign w_sym_nxt   = w_active_nxt && (w_cnt_nxt == '0);
    assign w_sam_nxt   = w_active_nxt && ((int'(w_cnt_nxt) % CLKS_PER_SAM) == 0);
    assign w_clear_nxt = w_active_nxt && (w_cnt_nxt == MAC_PH);
    assign w_dump_nxt  = (w_state_nxt != ST_IDLE) && w_done_nxt && (w_cnt_nxt == MAC_PH);

    assign phase = 4'(w_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            acc_clear  <= 1'b0;
            acc_dump   <= 1'b0;
            bank_sel   <= 2'd0;
            sym_count  <= 8'd0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
            sam_clk_en <= w_sam_nxt;
            sym_clk_en <= w_sym_nxt;
            acc_clear  <= w_clear_nxt;
            acc_dump   <= w_dump_nxt;
            busy       <= (w_state_nxt != ST_IDLE);
            // Bank and symbol count change only on the edge that opens a symbol.
            if (w_sym_nxt) begin
                bank_sel  <= sw;
                sym_count <= sym_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_filter_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_filter_tdm_sequencer
// Directed bench for filter_tdm_sequencer at default parameters
// (CLKS_PER_SAM=4, SAMS_PER_SYM=4, P=16, MAC_LAT=1). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_filter_tdm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [1:0] sw;
    logic       sam_clk_en;
    logic       sym_clk_en;
    logic [3:0] phase;
    logic       acc_clear;
    logic       acc_dump;
    logic [1:0] bank_sel;
    logic [7:0] sym_count;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    filter_tdm_sequencer #(
        .CLKS_PER_SAM (4),
        .SAMS_PER_SYM (4),
        .MAC_LAT      (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .sw         (sw),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .phase      (phase),
        .acc_clear  (acc_clear),
        .acc_dump   (acc_dump),
        .bank_sel   (bank_sel),
        .sym_count  (sym_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_sam, input logic e_sym,
                              input logic [3:0] e_phase, input logic e_clr,
                              input logic e_dump, input logic [1:0] e_bank,
                              input logic [7:0] e_cnt, input logic e_busy);
        check({tag, ".sam"},   8'(sam_clk_en), 8'(e_sam));
        check({tag, ".sym"},   8'(sym_clk_en), 8'(e_sym));
        check({tag, ".phase"}, 8'(phase),      8'(e_phase));
        check({tag, ".clr"},   8'(acc_clear),  8'(e_clr));
        check({tag, ".dump"},  8'(acc_dump),   8'(e_dump));
        check({tag, ".bank"},  8'(bank_sel),   8'(e_bank));
        check({tag, ".cnt"},   sym_count,      e_cnt);
        check({tag, ".busy"},  8'(busy),       8'(e_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_sym;
        int n_sam;
        int n_bad;
        int n_dump;
        bit saw_zero;

        reset = 1'b1;
        run   = 1'b0;
        sw    = 2'd0;
        #1;
        check_outs("reset", 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0);
        ticks(2);
        reset = 1'b0;
        ticks(2);
        check_outs("idle", 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0);

        // Cycle 0: run raised, first symbol opens on cycle 1.
        run = 1'b1;
        sw  = 2'd1;
        tick();
        check_outs("c1", 1, 1, 4'd0, 0, 0, 2'd1, 8'd1, 1);
        tick();
        check_outs("c2", 0, 0, 4'd1, 1, 0, 2'd1, 8'd1, 1);
        for (int c = 3; c <= 16; c++) begin
            tick();
            check("phase_run", 8'(phase), 8'(c - 1));
            check("sam_run", 8'(sam_clk_en), (((c - 1) % 4) == 0) ? 8'd1 : 8'd0);
        end
        tick();
        check_outs("c17", 1, 1, 4'd0, 0, 0, 2'd1, 8'd2, 1);
        tick();
        check_outs("c18", 0, 0, 4'd1, 1, 1, 2'd1, 8'd2, 1);

        // Bank request mid-symbol is held off until the next symbol.
        ticks(6);
        check("ph7", 8'(phase), 8'd7);
        sw = 2'd2;
        for (int c = 25; c <= 32; c++) begin
            tick();
            check("bank_hold", 8'(bank_sel), 8'd1);
        end
        check("ph15", 8'(phase), 8'd15);
        tick();
        check_outs("c33", 1, 1, 4'd0, 0, 0, 2'd2, 8'd3, 1);
        tick();
        check_outs("c34", 0, 0, 4'd1, 1, 1, 2'd2, 8'd3, 1);

        // Drop run at phase 5: symbol completes, then final dump at phase 1.
        ticks(4);
        check("ph5", 8'(phase), 8'd5);
        run = 1'b0;
        ticks(10);
        check_outs("drain_ph15", 0, 0, 4'd15, 0, 0, 2'd2, 8'd3, 1);
        tick();
        check_outs("tail_ph0", 0, 0, 4'd0, 0, 0, 2'd2, 8'd3, 1);
        tick();
        check_outs("tail_dump", 0, 0, 4'd1, 0, 1, 2'd2, 8'd3, 1);
        tick();
        check_outs("idle_after", 0, 0, 4'd0, 0, 0, 2'd2, 8'd3, 0);
        ticks(3);
        check_outs("quiet", 0, 0, 4'd0, 0, 0, 2'd2, 8'd3, 0);

        // Restart from IDLE: no dump in the first symbol.
        run = 1'b1;
        tick();
        check_outs("s4_start", 1, 1, 4'd0, 0, 0, 2'd2, 8'd4, 1);
        tick();
        check_outs("s4_ph1", 0, 0, 4'd1, 1, 0, 2'd2, 8'd4, 1);

        // run dips low mid-symbol and returns: next symbol follows with no gap.
        ticks(2);
        run = 1'b0;
        ticks(7);
        check("ph10", 8'(phase), 8'd10);
        run = 1'b1;
        sw  = 2'd3;
        ticks(5);
        check_outs("s4_ph15", 0, 0, 4'd15, 0, 0, 2'd2, 8'd4, 1);
        tick();
        check_outs("s5_nogap", 1, 1, 4'd0, 0, 0, 2'd3, 8'd5, 1);
        tick();
        check_outs("s5_ph1", 0, 0, 4'd1, 1, 1, 2'd3, 8'd5, 1);

        // Asynchronous reset at phase 9 clears everything within the cycle.
        ticks(8);
        check("ph9", 8'(phase), 8'd9);
        reset = 1'b1;
        #1;
        check_outs("rst_mid", 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0);
        ticks(2);
        check_outs("rst_hold", 0, 0, 4'd0, 0, 0, 2'd0, 8'd0, 0);
        reset = 1'b0;
        tick();
        check_outs("post_rst", 1, 1, 4'd0, 0, 0, 2'd3, 8'd1, 1);
        tick();
        check_outs("post_rst_ph1", 0, 0, 4'd1, 1, 0, 2'd3, 8'd1, 1);

        // 259 more symbols: sym_count runs 2..255, 0..4.
        n_sym    = 0;
        n_sam    = 0;
        n_bad    = 0;
        saw_zero = 1'b0;
        for (int c = 0; c < 259 * 16; c++) begin
            tick();
            if (sam_clk_en) n_sam++;
            if (sym_clk_en) begin
                n_sym++;
                if (sym_count !== 8'((1 + n_sym) % 256)) n_bad++;
                if (phase !== 4'd0) n_bad++;
                if (sym_count === 8'd0) saw_zero = 1'b1;
            end
        end
        check("wrap_sym_strobes", 8'(n_sym),       8'(259));
        check("wrap_sam_strobes", 8'(n_sam / 4),   8'(259));
        check("wrap_sam_rem",     8'(n_sam % 4),   8'd0);
        check("wrap_seq_errors",  8'(n_bad),       8'd0);
        check("wrap_saw_zero",    8'(saw_zero),    8'd1);
        check("wrap_final_cnt",   sym_count,       8'd4);

        // Final drain, bounded wait for busy to fall.
        run    = 1'b0;
        n_dump = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (acc_dump) n_dump++;
            if (!busy) break;
        end
        check("end_busy",  8'(busy),      8'd0);
        check("end_dumps", 8'(n_dump),    8'd1);
        check("end_cnt",   sym_count,     8'd4);
        check("end_phase", 8'(phase),     8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_tdm_sequencer.md
FILTER_TDM_SEQUENCER -- requirements
Module: filter_tdm_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_SAM, default 4, system clocks per sample-enable.
REQ-002 SHALL have parameter SAMS_PER_SYM, default 4, sample-enables per symbol-enable.
REQ-003 SHALL have parameter MAC_LAT, default 1, multiplier pipeline depth in clocks; legal range 0..(CLKS_PER_SAM*SAMS_PER_SYM-1).
REQ-004 SHALL have the following ports, clock and reset first:
  clk  in  1  single system clock; all state changes on rising edge.
  reset  in  1  asynchronous, active-high reset.
  run  in  1  level; 1 requests continuous filter sequencing.
  sw  in  2  coefficient-bank request.
  sam_clk_en  out  1  one-clock sample strobe.
  sym_clk_en  out  1  one-clock symbol strobe.
  phase  out  4  time-share phase index, equal to the symbol-period clock count.
  acc_clear  out  1  accumulators load the new product instead of adding.
  acc_dump  out  1  accumulator totals are final; downstream captures them.
  bank_sel  out  2  coefficient bank in effect for the current symbol.
  sym_count  out  8  symbols started since reset, modulo 256.
  busy  out  1  sequencer not IDLE.

Function
REQ-005 SHALL define the period P = CLKS_PER_SAM*SAMS_PER_SYM (16 at defaults); internal count cnt runs 0..P-1 and wraps P-1 -> 0.
REQ-006 SHALL implement states IDLE, RUN, DRAIN; all outputs SHALL be registered (Moore).
REQ-007 IDLE: cnt=0, all strobes 0, busy=0; run=1 sampled -> RUN, first RUN cycle has cnt=0.
REQ-008 RUN: cnt increments each clock; run=0 sampled -> DRAIN, counting continues.
REQ-009 DRAIN: counting continues to cnt=P-1; at that edge -> IDLE if run=0, -> RUN with cnt=0 if run=1 (no gap cycle).
REQ-010 In RUN/DRAIN: sam_clk_en=1 iff cnt mod CLKS_PER_SAM = 0; sym_clk_en=1 iff cnt=0; phase=cnt.
REQ-011 acc_clear SHALL be 1 iff cnt = MAC_LAT mod P, in RUN/DRAIN cycles that fall within an active symbol.
REQ-012 acc_dump SHALL be 1 iff cnt = MAC_LAT mod P and at least one full symbol has completed since leaving IDLE; a final acc_dump SHALL follow the last drained symbol, with busy held 1 until that cycle.
REQ-013 bank_sel SHALL load sw on the edge entering cnt=0 (new bank valid in the sym_clk_en cycle); sw changes mid-symbol SHALL be ignored until the next symbol.
REQ-014 sym_count SHALL increment on each sym_clk_en cycle, wrapping 255 -> 0.
REQ-015 Outside RUN/DRAIN, sam_clk_en, sym_clk_en, acc_clear, acc_dump SHALL be 0 and phase SHALL be 0.
REQ-016 run toggling within one symbol SHALL never shorten a symbol; every started symbol completes all P phases.

Reset
REQ-017 reset=1 SHALL immediately force IDLE, cnt=0, phase=0, bank_sel=0, sym_count=0, busy=0, all strobes 0, regardless of clock.
REQ-018 Reset mid-symbol SHALL abandon that symbol with no acc_dump; the first post-reset symbol starts one clock after run is sampled 1.

Structure
REQ-019 Package filter_tdm_pkg SHALL hold the state enumeration and default constants CLKS_PER_SAM=4, SAMS_PER_SYM=4, P=16.
REQ-020 The phase counter SHALL be one sub-module, mod_counter (parameterised modulus, enable, synchronous clear, wrap flag).

Verification
REQ-021 reset released, run=1 at cycle 0 -> sym_clk_en at cycles 1,17,33; sam_clk_en at 1,5,9,13,17; phase 0..15 repeating from cycle 1.
REQ-022 MAC_LAT=1, run held -> acc_clear at phase 1 each symbol; first acc_dump at phase 1 of symbol 2 (cycle 18).
REQ-023 run dropped at phase 5 -> counting to phase 15, final acc_dump at phase 1 (MAC_LAT) of the following period, busy falls the next clock, no further strobes.
REQ-024 sw=2 set at phase 7 -> bank_sel stays old value through phase 15, becomes 2 at next sym_clk_en.
REQ-025 reset pulsed at phase 9 -> all outputs 0 same cycle; re-run yields sym_count=1 after first new sym_clk_en.
REQ-026 260 continuous symbols -> sym_count wraps 255 -> 0 -> 4; no missing or extra strobe.
